// File: rtl/cam_nway.sv
// N-way set-associative tag+data store with tree pseudo-LRU replacement
// and a flush sequencer that clears every set after reset or on request.
module cam_nway #(
    parameter int WAYS       = 2,
    parameter int SETS_LOG2  = 8,
    parameter int WORDS_LOG2 = 2,
    parameter int TAG_W      = 17,
    parameter int FLAGS_W    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            busy,
    input  logic                            flush_req,
    output logic                            flush_done,
    input  logic                            read_req,
    input  logic [SETS_LOG2+WORDS_LOG2-1:0] read_index,
    input  logic [TAG_W-1:0]                read_tag,
    output logic                            read_hit,
    output logic [WAYS-1:0]                 read_way,
    output logic [31:0]                     read_data,
    input  logic                            write_req,
    input  logic                            write_lru_way,
    input  logic [WORDS_LOG2-1:0]           write_offset,
    input  logic [31:0]                     write_data,
    input  logic [3:0]                      write_mask,
    input  logic [TAG_W-1:0]                write_tag,
    input  logic [FLAGS_W-1:0]              write_flags,
    input  logic                            lru_update,
    output logic [TAG_W-1:0]                lru_tag,
    output logic [FLAGS_W-1:0]              lru_flags,
    output logic [WAYS-1:0]                 lru_way
);

    localparam int SETS   = 1 << SETS_LOG2;
    localparam int LINE_W = SETS_LOG2 + WORDS_LOG2;
    localparam int PLRU_W = WAYS - 1;
    localparam int LEVELS = $clog2(WAYS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
    logic [FLAGS_W-1:0] flag_mem [WAYS][SETS];
    logic [31:0]        data_mem [WAYS][SETS << WORDS_LOG2];
    logic [PLRU_W-1:0]  plru_mem [SETS];

    logic [0:0]            state;
    logic [SETS_LOG2-1:0]  cnt;
    logic                  rd_valid;
    logic [SETS_LOG2-1:0]  rd_set;
    logic [WORDS_LOG2-1:0] rd_word;
    logic [PLRU_W-1:0]     rd_plru;

    logic            rd_acc;
    logic            out_en;
    logic            wr_en;
    logic            upd_en;
    logic [WAYS-1:0] write_way;
    logic [WAYS-1:0] acc_way;
    logic [PLRU_W-1:0] plru_new;

    assign busy   = (state == ST_FLUSH);
    assign rd_acc = read_req & ~busy;
    assign out_en = rd_valid & ~busy;
    // A flush request in IDLE also drops any write or PLRU update of that cycle.
    assign wr_en  = write_req & ~busy & ~flush_req;
    assign upd_en = lru_update & ~busy & ~flush_req & (read_hit | write_req) & (|acc_way);

    // rd_set doubles as the write set: both follow every accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FLUSH;
            cnt        <= '0;
            flush_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_set     <= '0;
            rd_word    <= '0;
            rd_plru    <= '0;
        end else begin
            flush_done <= 1'b0;
            rd_valid   <= rd_acc;
            if (rd_acc) begin
                rd_set  <= read_index[LINE_W-1:WORDS_LOG2];
                rd_word <= read_index[WORDS_LOG2-1:0];
                rd_plru <= plru_mem[read_index[LINE_W-1:WORDS_LOG2]];
            end
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_FLUSH;
                        cnt   <= '0;
                    end
                end
                default: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state      <= ST_IDLE;
                        flush_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        read_way  = '0;
        read_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            read_way[w] = out_en && flag_mem[w][rd_set][0] && (tag_mem[w][rd_set] == read_tag);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (read_way[w]) read_data = read_data | data_mem[w][{rd_set, rd_word}];
        end
    end

    assign read_hit = |read_way;

    // Victim: lowest invalid way, otherwise follow the PLRU tree (heap order, node 1 = root).
    always_comb begin
        int   node;
        logic b;
        logic found;
        node = 1;
        for (int l = 0; l < LEVELS; l++) begin
            b = 1'b0;
            for (int n = 1; n < WAYS; n++) begin
                if (n == node) b = rd_plru[n-1];
            end
            node = 2 * node + (b ? 1 : 0);
        end
        found   = 1'b0;
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !flag_mem[w][rd_set][0]) begin
                found      = 1'b1;
                lru_way[w] = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) lru_way[w] = ((node - WAYS) == w);
        end
    end

    always_comb begin
        lru_tag   = '0;
        lru_flags = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lru_way[w]) begin
                lru_tag   = lru_tag | tag_mem[w][rd_set];
                lru_flags = lru_flags | flag_mem[w][rd_set];
            end
        end
    end

    assign write_way = write_lru_way ? lru_way : read_way;

    // Each tree node on the accessed path is turned to point away from that way.
    always_comb begin
        int   node;
        int   idx;
        logic d;
        acc_way = write_req ? write_way : read_way;
        idx = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (acc_way[w]) idx = w;
        end
        plru_new = plru_mem[rd_set];
        node = 1;
        for (int l = 0; l < LEVELS; l++) begin
            d = (((idx >> (LEVELS - 1 - l)) & 1) != 0);
            for (int n = 1; n < WAYS; n++) begin
                if (n == node) plru_new[n-1] = !d;
            end
            node = 2 * node + (d ? 1 : 0);
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[w][cnt]  <= '0;
                flag_mem[w][cnt] <= '0;
            end
            plru_mem[cnt] <= '0;
        end else begin
            if (wr_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (write_way[w]) begin
                        tag_mem[w][rd_set]  <= write_tag;
                        flag_mem[w][rd_set] <= write_flags;
                        for (int b = 0; b < 4; b++) begin
                            if (write_mask[b])
                                data_mem[w][{rd_set, write_offset}][8*b +: 8] <= write_data[8*b +: 8];
                        end
                    end
                end
            end
            if (upd_en) plru_mem[rd_set] <= plru_new;
        end
    end

endmodule

// File: tb/tb_cam_nway.sv
// Directed bench for cam_nway (4-way): flush timing, hit/miss, forwarding,
// PLRU victim order, invalid-way preference, reset during flush.
module tb_cam_nway;

    logic        clk;
    logic        reset;
    logic        busy;
    logic        flush_req;
    logic        flush_done;
    logic        read_req;
    logic [9:0]  read_index;
    logic [16:0] read_tag;
    logic        read_hit;
    logic [3:0]  read_way;
    logic [31:0] read_data;
    logic        write_req;
    logic        write_lru_way;
    logic [1:0]  write_offset;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic [16:0] write_tag;
    logic [1:0]  write_flags;
    logic        lru_update;
    logic [16:0] lru_tag;
    logic [1:0]  lru_flags;
    logic [3:0]  lru_way;

    cam_nway #(.WAYS(4), .SETS_LOG2(8), .WORDS_LOG2(2), .TAG_W(17), .FLAGS_W(2)) dut (
        .clk(clk), .reset(reset), .busy(busy),
        .flush_req(flush_req), .flush_done(flush_done),
        .read_req(read_req), .read_index(read_index), .read_tag(read_tag),
        .read_hit(read_hit), .read_way(read_way), .read_data(read_data),
        .write_req(write_req), .write_lru_way(write_lru_way), .write_offset(write_offset),
        .write_data(write_data), .write_mask(write_mask), .write_tag(write_tag),
        .write_flags(write_flags), .lru_update(lru_update),
        .lru_tag(lru_tag), .lru_flags(lru_flags), .lru_way(lru_way)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;
    int rd_num;
    logic rd_issued;
    logic rd_due;
    // {chk_data, chk_lru, hit, way[3:0], lru[3:0], data[31:0]}
    logic [42:0] exp_q[$];

    // scoreboard monitor
    always @(posedge clk) rd_due <= rd_issued;

    always @(negedge clk) begin
        if (rd_due) begin
            logic [42:0] e;
            logic ok;
            vectors++;
            rd_num++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL read#%0d: result with empty expected queue, hit %0b way %b", rd_num, read_hit, read_way);
            end else begin
                e = exp_q.pop_front();
                ok = (read_hit == e[40]) && (read_way == e[39:36]) && ($countones(read_way) <= 1)
                     && (!e[42] || read_data == e[31:0]) && (!e[41] || lru_way == e[35:32]);
                if (!ok) begin
                    miscompares++;
                    $display("FAIL read#%0d: got hit %0b way %b data %h lru %b, expected hit %0b way %b data %h lru %b",
                             rd_num, read_hit, read_way, read_data, lru_way, e[40], e[39:36], e[31:0], e[35:32]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit cd, input logic [31:0] d, input bit h, input logic [3:0] w,
                        input bit cl, input logic [3:0] l);
        exp_q.push_back({cd, cl, h, w, l, d});
    endtask

    // driver tasks
    task automatic inputs_idle();
        flush_req = 0; read_req = 0; read_index = '0; read_tag = '0;
        write_req = 0; write_lru_way = 0; write_offset = '0; write_data = '0;
        write_mask = '0; write_tag = '0; write_flags = '0; lru_update = 0;
        rd_issued = 0;
    endtask

    task automatic junk_on();
        read_req = 1; read_index = {8'd3, 2'd0}; read_tag = 17'h0F0F0;
        write_req = 1; write_lru_way = 1; write_offset = 2'd0; write_data = 32'hFFFF_FFFF;
        write_mask = 4'hF; write_tag = 17'h0F0F0; write_flags = 2'b01; lru_update = 1;
    endtask

    // One cycle: rtag is the compare tag for the read issued in the previous step.
    task automatic step(input bit rreq, input int rset, input int rword, input logic [16:0] rtag,
                        input bit wreq = 1'b0, input bit wlru = 1'b0, input int woff = 0,
                        input logic [31:0] wdata = '0, input logic [3:0] wmask = '0,
                        input logic [16:0] wtag = '0, input logic [1:0] wflags = '0,
                        input bit lupd = 1'b0);
        @(posedge clk); #1;
        read_req      = rreq;
        read_index    = {rset[7:0], rword[1:0]};
        read_tag      = rtag;
        write_req     = wreq;
        write_lru_way = wlru;
        write_offset  = woff[1:0];
        write_data    = wdata;
        write_mask    = wmask;
        write_tag     = wtag;
        write_flags   = wflags;
        lru_update    = lupd;
        rd_issued     = rreq;
    endtask

    task automatic run_flush(input bit junk, output int n_busy, output int n_done, output int n_loud);
        n_busy = 0; n_done = 0; n_loud = 0;
        if (junk) junk_on();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (flush_done) n_done++;
            if (busy && (read_hit || read_way != 0 || read_data != 0)) n_loud++;
            if (junk && i == 250) inputs_idle();
        end
    endtask

    logic [16:0] t [4];
    logic [31:0] d [4];
    logic [3:0]  exp_l [4];
    logic [3:0]  one;

    initial begin
        int nb, nd, nl;
        vectors = 0; miscompares = 0; rd_num = 0; rd_due = 0;
        one = 4'b0001;
        t = '{17'h00A00, 17'h00A01, 17'h00A02, 17'h00A03};
        d = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003};
        exp_l = '{4'b0001, 4'b0100, 4'b0100, 4'b0001};
        inputs_idle();
        reset = 0;
        #3 reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_read_hit", read_hit, 0);
        chk("rst_read_way", read_way, 0);
        chk("rst_read_data", read_data, 0);
        @(posedge clk); #1 reset = 0;

        run_flush(0, nb, nd, nl);
        chk("flush0_busy_cycles", nb, 256);
        chk("flush0_done_pulses", nd, 1);
        chk("flush0_quiet", nl, 0);

        // miss after flush, fill, hit, forwarding
        step(1, 7, 0, 17'h0);            push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(1, 5, 0, 17'h00123);        push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(0, 0, 0, 17'h1ABCD, 1, 1, 0, 32'hDEADBEEF, 4'hF, 17'h1ABCD, 2'b01);
        step(1, 5, 1, 17'h0);            push(0, 32'h0, 1, 4'b0001, 1, 4'b0010);
        step(0, 0, 0, 17'h1ABCD, 1, 0, 1, 32'hAABBCCDD, 4'hF, 17'h1ABCD, 2'b01);
        step(1, 5, 0, 17'h0);            push(1, 32'hDEADBEEF, 1, 4'b0001, 1, 4'b0010);
        step(1, 5, 1, 17'h1ABCD);        push(1, 32'hAABBCCDD, 1, 4'b0001, 0, 4'b0000);
        step(1, 5, 1, 17'h1ABCD, 1, 0, 1, 32'h11223344, 4'b0011, 17'h1ABCD, 2'b01);
        push(1, 32'hAABB3344, 1, 4'b0001, 0, 4'b0000);
        step(0, 0, 0, 17'h1ABCD);

        // fill set 9: the victim walks through the invalid ways in order
        for (int i = 0; i < 4; i++) begin
            step(1, 9, 0, 17'h0);        push(1, 32'h0, 0, 4'b0000, 1, one << i);
            step(0, 0, 0, t[i], 1, 1, 0, d[i], 4'hF, t[i], 2'b01);
        end
        // PLRU order with updates on every hit
        for (int i = 0; i < 4; i++) begin
            step(1, 9, 0, 17'h0);        push(1, d[i], 1, one << i, 1, exp_l[i]);
            step(0, 0, 0, t[i], 0, 0, 0, 32'h0, 4'h0, 17'h0, 2'b00, 1);
        end
        step(1, 9, 0, 17'h0);            push(1, d[0], 1, 4'b0001, 1, 4'b0001);
        step(0, 0, 0, t[0], 0, 0, 0, 32'h0, 4'h0, 17'h0, 2'b00, 1);
        step(1, 9, 0, 17'h0);            push(1, d[1], 1, 4'b0010, 1, 4'b0100);
        step(0, 0, 0, t[1]);
        // invalidate way 2 while turning the tree towards way 1
        step(1, 9, 0, 17'h0);            push(1, d[2], 1, 4'b0100, 1, 4'b0100);
        step(0, 0, 0, t[2], 1, 0, 0, 32'h0, 4'h0, t[2], 2'b00, 1);
        step(1, 9, 0, 17'h0);            push(1, d[0], 1, 4'b0001, 1, 4'b0100);
        step(1, 9, 0, t[0]);             push(1, 32'h0, 0, 4'b0000, 1, 4'b0100);
        step(1, 9, 0, t[2]);             push(1, d[3], 1, 4'b1000, 1, 4'b0100);
        step(0, 0, 0, t[3]);

        // flush, then reset at flush cycle 100 with junk traffic throughout
        @(posedge clk); #1;
        inputs_idle();
        flush_req = 1;
        @(posedge clk); #1;
        flush_req = 0;
        junk_on();
        nb = 0; nd = 0; nl = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (flush_done) nd++;
            if (busy && (read_hit || read_way != 0 || read_data != 0)) nl++;
        end
        chk("flush1_busy_before_reset", nb, 100);
        chk("flush1_done_before_reset", nd, 0);
        chk("flush1_quiet", nl, 0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("rst2_busy", busy, 1);
        chk("rst2_read_hit", read_hit, 0);
        @(posedge clk); #1 reset = 0;
        run_flush(1, nb, nd, nl);
        chk("flush2_busy_cycles", nb, 256);
        chk("flush2_done_pulses", nd, 1);
        chk("flush2_quiet", nl, 0);

        // everything misses afterwards; no dropped write survived
        step(1, 5, 0, 17'h0);            push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(1, 9, 0, 17'h1ABCD);        push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(1, 9, 0, t[0]);             push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(1, 0, 0, 17'h0F0F0);        push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(1, 3, 0, 17'h0F0F0);        push(1, 32'h0, 0, 4'b0000, 1, 4'b0001);
        step(0, 0, 0, 17'h0F0F0);
        step(0, 0, 0, 17'h0);
        @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_nway.md
Name: cam_nway

Overview:
- Parametrised N-way set-associative tag+data store; successor to the 2-way cache store used by the I/D caches.
- Generalises ways, sets, words per line, tag and flag widths.
- Adds tree pseudo-LRU replacement with invalid-way preference and a hardware invalidate-all sequencer.
- The sequencer also runs after reset, so no simulation-only memory init is needed.

Parameters:
WAYS, 2, associativity; power of two, 2..8
SETS_LOG2, 8, log2 number of sets
WORDS_LOG2, 2, log2 32-bit words per line
TAG_W, 17, tag width
FLAGS_W, 2, flag width; flags[0] is the valid bit

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
busy  out  1  flush in progress; all requests ignored
flush_req  in  1  pulse; start invalidate-all
flush_done  out  1  one-cycle pulse when flush completes
read_req  in  1  read request
read_index  in  SETS_LOG2+WORDS_LOG2  {set,word} address
read_tag  in  TAG_W  compare tag, presented the cycle after read_req
read_hit  out  1  hit, valid the cycle after read_req
read_way  out  WAYS  one-hot hit way (0 on miss)
read_data  out  32  data of hit way (0 on miss)
write_req  in  1  write request to the set of the last accepted read
write_lru_way  in  1  1: write victim way; 0: write read_way
write_offset  in  WORDS_LOG2  word within line
write_data  in  32  write data
write_mask  in  4  byte enables
write_tag  in  TAG_W  tag written to the selected way
write_flags  in  FLAGS_W  flags written to the selected way
lru_update  in  1  qualify replacement-state update (same-cycle semantics as the read result)
lru_tag  out  TAG_W  victim way tag
lru_flags  out  FLAGS_W  victim way flags
lru_way  out  WAYS  one-hot victim way

Behaviour:
- Reset (async): FSM enters FLUSH, set counter = 0, busy = 1, flush_done = 0, read_hit = 0, read_way = 0, read_data = 0.
- Reset mid-flush restarts at set 0.
- FSM states:
  - IDLE: flush_req -> FLUSH, counter = 0.
  - FLUSH: each cycle clears tag/flags of all ways and the PLRU bits of set[counter], then counter++.
  - After set 2^SETS_LOG2-1 is cleared, the next cycle returns to IDLE with flush_done = 1 for exactly that cycle.
  - Flush duration: exactly 2^SETS_LOG2 cycles of busy.
  - flush_req during FLUSH is ignored.
- While busy:
  - read_req does not latch a write set.
  - read_hit, read_way and read_data are 0.
  - write_req and lru_update are dropped.
- Read: one-cycle latency.
  - Way i hits iff flags[0] of way i is set and its tag == read_tag.
  - read_data = OR of hit-way data.
  - Multiple hits are illegal; the bench flags them.
- Write set: register loaded with the set field of read_index on every accepted read_req; write_req targets {write set, write_offset}.
- write_way = write_lru_way ? lru_way : read_way.
  - write_lru_way = 0 on a miss writes nothing.
  - Data bytes are written per write_mask; tag and flags are written whole.
- Forwarding: read_req and write_req in the same cycle to the same set.
  - Next-cycle tag/flags of the written way come from the write.
  - If the word also matches, next-cycle data bytes enabled in write_mask come from the write.
- Replacement:
  - WAYS-1 tree PLRU bits per set.
  - Victim: lowest-index way with flags[0] = 0 if one exists, else the way indicated by the PLRU tree.
  - Victim is evaluated on the set read last cycle; lru_tag, lru_flags and lru_way are valid alongside read_hit.
  - With WAYS = 2 and all ways valid, behaves as true LRU.
- PLRU update: when lru_update & ((read accepted last cycle & read_hit) | write_req).
  - Tree bits on the path point away from the accessed way: write_way if write_req, else read_way.
  - The update goes to the write set.
  - A read of the same set in the same cycle sees the pre-update PLRU; no PLRU forwarding.
- Flush and simultaneous write_req on the flush-start cycle: the write is dropped.

Test Plan:
- Release reset, default params -> busy high exactly 256 cycles, one flush_done pulse, then a read of any set with any tag gives read_hit = 0 and lru_way = 2'b01.
- WAYS = 4: read set 5 tag 0x1ABCD miss; write_lru_way = 1, data 0xDEADBEEF, mask 4'hF, flags 2'b01 -> way 0 filled; re-read -> read_hit = 1, read_way = 4'b0001, read_data = 0xDEADBEEF.
- Same-cycle read and write, same set and word, mask 4'b0011, write_data 0x11223344 over 0xAABBCCDD -> next-cycle read_data = 0xAABB3344.
- WAYS = 4, set fully valid: access ways 0, 1, 2, 3 with lru_update -> lru_way = 4'b0001; access 0 again -> lru_way = 4'b0100.
- WAYS = 4, ways 0, 1, 3 valid and way 2 invalid -> lru_way = 4'b0100 regardless of PLRU bits.
- Fill several sets, pulse flush_req, assert reset at flush cycle 100 -> flush restarts, busy stays high 256 cycles from reset, all reads then miss, and writes issued during busy leave no effect.
